// File: rtl/conv_sched_pkg.sv
// Shared state encoding, width helper and default-geometry constants for the
// convolution layer scheduler.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StKstart,
    StFeedWait,
    StRd,
    StCap,
    StPresent,
    StDrain,
    StFinish
  } sched_state_e;

  // Address/select width that never collapses to zero bits.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NUM_PIXELS     = 8 * 8;
  localparam int unsigned OUT_PER_KERNEL = (8 - 3 + 1) * (8 - 3 + 1);
  localparam int unsigned PIX_ADDR_W     = width_of(NUM_PIXELS);
  localparam int unsigned OBUF_ADDR_W    = width_of(4 * OUT_PER_KERNEL);
  localparam int unsigned KSEL_W         = width_of(4);

endpackage

// File: rtl/conv_sched_out_writer.sv
// Output-buffer writer: kernel-major addressing, per-kernel output count and
// count-mismatch detection. CONV_SCHED_RELU_EN clamps negative results to zero.
module conv_sched_out_writer
  import conv_sched_pkg::*;
#(
  parameter int unsigned OUT_BIN_LEN    = 16,
  parameter int unsigned OUT_PER_KERNEL = 36,
  parameter int unsigned KSEL_W         = 2,
  parameter int unsigned OBUF_ADDR_W    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   active,
  input  logic                   cnt_clr,
  input  logic [KSEL_W-1:0]      kernel_sel,
  input  logic [OUT_BIN_LEN-1:0] pu_output_val,
  input  logic                   pu_output_valid,
  input  logic                   pu_done,
  output logic                   obuf_wr_en,
  output logic [OBUF_ADDR_W-1:0] obuf_wr_addr,
  output logic [OUT_BIN_LEN-1:0] obuf_wr_data,
  output logic                   wr_err
);

  localparam int unsigned OCNT_W = width_of(OUT_PER_KERNEL + 1);

  logic [OCNT_W-1:0]      out_cnt;
  logic                   full;
  logic [OUT_BIN_LEN-1:0] shaped_val;

  assign full = (out_cnt == OCNT_W'(OUT_PER_KERNEL));

`ifdef CONV_SCHED_RELU_EN
  assign shaped_val = pu_output_val[OUT_BIN_LEN-1] ? '0 : pu_output_val;
`else
  assign shaped_val = pu_output_val;
`endif

  always_comb begin
    // A strobe past the end of the kernel row is dropped and flagged instead.
    obuf_wr_en   = active && pu_output_valid && !full;
    obuf_wr_addr = OBUF_ADDR_W'(kernel_sel) * OBUF_ADDR_W'(OUT_PER_KERNEL)
                 + OBUF_ADDR_W'(out_cnt);
    obuf_wr_data = obuf_wr_en ? shaped_val : '0;
    wr_err       = active && ((pu_output_valid && full) || (pu_done && !full));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_cnt <= '0;
    end else if (cnt_clr) begin
      out_cnt <= '0;
    end else if (obuf_wr_en) begin
      out_cnt <= out_cnt + OCNT_W'(1);
    end
  end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Runs one processing unit over a whole convolution layer, one pass per kernel,
// feeding raster-order pixels and storing results kernel-major (ReLU: CONV_SCHED_RELU_EN).
module conv_layer_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned BIN_LEN       = 8,
  parameter int unsigned OUT_BIN_LEN   = 16,
  parameter int unsigned INPUT_WIDTH   = 8,
  parameter int unsigned INPUT_HEIGHT  = 8,
  parameter int unsigned KERNEL_WIDTH  = 3,
  parameter int unsigned KERNEL_HEIGHT = 3,
  parameter int unsigned NUM_KERNELS   = 4
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        layer_start,
  output logic                                        layer_busy,
  output logic                                        layer_done,
  output logic                                        err,
  output logic [width_of(NUM_KERNELS)-1:0]            kernel_sel,
  output logic                                        pu_start,
  input  logic                                        pu_input_req,
  output logic                                        pu_input_ready,
  output logic [BIN_LEN-1:0]                          pu_input_val,
  input  logic [OUT_BIN_LEN-1:0]                      pu_output_val,
  input  logic                                        pu_output_valid,
  input  logic                                        pu_done,
  output logic                                        ibuf_rd_en,
  output logic [width_of(INPUT_WIDTH*INPUT_HEIGHT)-1:0] ibuf_rd_addr,
  input  logic [BIN_LEN-1:0]                          ibuf_rd_data,
  output logic                                        obuf_wr_en,
  output logic [width_of(NUM_KERNELS*(INPUT_WIDTH-KERNEL_WIDTH+1)*
                         (INPUT_HEIGHT-KERNEL_HEIGHT+1))-1:0] obuf_wr_addr,
  output logic [OUT_BIN_LEN-1:0]                      obuf_wr_data
);

  localparam int unsigned NPIX   = INPUT_WIDTH * INPUT_HEIGHT;
  localparam int unsigned OPK    = (INPUT_WIDTH - KERNEL_WIDTH + 1) *
                                   (INPUT_HEIGHT - KERNEL_HEIGHT + 1);
  localparam int unsigned PIX_W  = width_of(NPIX);
  localparam int unsigned PCNT_W = width_of(NPIX + 1);
  localparam int unsigned K_W    = width_of(NUM_KERNELS);
  localparam int unsigned OBUF_W = width_of(NUM_KERNELS * OPK);

  sched_state_e      state;
  logic [PCNT_W-1:0] pix_cnt;
  logic              active;
  logic              accept;
  logic              kernel_last;
  logic              advance;
  logic              cnt_clr;
  logic              stray_done;
  logic              wr_err;

  assign active      = (state != StIdle);
  assign accept      = (state == StIdle) && layer_start;
  assign kernel_last = (kernel_sel == K_W'(NUM_KERNELS - 1));
  assign advance     = (state == StDrain) && pu_done && !kernel_last;
  assign cnt_clr     = accept || advance;
  assign stray_done  = pu_done && (state != StDrain);

  conv_sched_out_writer #(
    .OUT_BIN_LEN    (OUT_BIN_LEN),
    .OUT_PER_KERNEL (OPK),
    .KSEL_W         (K_W),
    .OBUF_ADDR_W    (OBUF_W)
  ) u_out_writer (
    .clock           (clock),
    .reset           (reset),
    .active          (active),
    .cnt_clr         (cnt_clr),
    .kernel_sel      (kernel_sel),
    .pu_output_val   (pu_output_val),
    .pu_output_valid (pu_output_valid),
    .pu_done         (pu_done),
    .obuf_wr_en      (obuf_wr_en),
    .obuf_wr_addr    (obuf_wr_addr),
    .obuf_wr_data    (obuf_wr_data),
    .wr_err          (wr_err)
  );

  // Strobe outputs are registered from the transition into the state they belong to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= StIdle;
      pix_cnt        <= '0;
      kernel_sel     <= '0;
      layer_busy     <= 1'b0;
      layer_done     <= 1'b0;
      err            <= 1'b0;
      pu_start       <= 1'b0;
      pu_input_ready <= 1'b0;
      pu_input_val   <= '0;
      ibuf_rd_en     <= 1'b0;
      ibuf_rd_addr   <= '0;
    end else begin
      pu_start       <= 1'b0;
      pu_input_ready <= 1'b0;
      ibuf_rd_en     <= 1'b0;
      layer_done     <= 1'b0;
      err            <= (accept ? 1'b0 : err) | wr_err | stray_done;

      unique case (state)
        StIdle: begin
          if (layer_start) begin
            state      <= StKstart;
            kernel_sel <= '0;
            pix_cnt    <= '0;
            layer_busy <= 1'b1;
            pu_start   <= 1'b1;
          end
        end
        StKstart: state <= StFeedWait;
        StFeedWait: begin
          if (pix_cnt == PCNT_W'(NPIX)) begin
            state <= StDrain;
          end else if (pu_input_req) begin
            state        <= StRd;
            ibuf_rd_en   <= 1'b1;
            ibuf_rd_addr <= pix_cnt[PIX_W-1:0];
          end
        end
        StRd: state <= StCap;
        StCap: begin
          state          <= StPresent;
          pu_input_val   <= ibuf_rd_data;
          pu_input_ready <= 1'b1;
        end
        StPresent: begin
          state   <= StFeedWait;
          pix_cnt <= pix_cnt + PCNT_W'(1);
        end
        StDrain: begin
          if (pu_done) begin
            if (kernel_last) begin
              state      <= StFinish;
              layer_done <= 1'b1;
              layer_busy <= 1'b0;
            end else begin
              state      <= StKstart;
              kernel_sel <= kernel_sel + K_W'(1);
              pix_cnt    <= '0;
              pu_start   <= 1'b1;
            end
          end
        end
        StFinish: state <= StIdle;
        default:  state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Self-checking bench for conv_layer_scheduler: 4x4 input, 3x3 kernel, two kernels,
// with a behavioural processing unit, input buffer and write scoreboard.
module tb_conv_layer_scheduler;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int K    = 3;
  localparam int NK   = 2;
  localparam int NPIX = W * H;
  localparam int OPK  = (W - K + 1) * (H - K + 1);

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        layer_start;
  logic        layer_busy;
  logic        layer_done;
  logic        err;
  logic [0:0]  kernel_sel;
  logic        pu_start;
  logic        pu_input_req;
  logic        pu_input_ready;
  logic [7:0]  pu_input_val;
  logic [15:0] pu_output_val;
  logic        pu_output_valid;
  logic        pu_done;
  logic        ibuf_rd_en;
  logic [3:0]  ibuf_rd_addr;
  logic [7:0]  ibuf_rd_data;
  logic        obuf_wr_en;
  logic [2:0]  obuf_wr_addr;
  logic [15:0] obuf_wr_data;

  conv_layer_scheduler #(
    .BIN_LEN       (8),
    .OUT_BIN_LEN   (16),
    .INPUT_WIDTH   (W),
    .INPUT_HEIGHT  (H),
    .KERNEL_WIDTH  (K),
    .KERNEL_HEIGHT (K),
    .NUM_KERNELS   (NK)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .layer_start     (layer_start),
    .layer_busy      (layer_busy),
    .layer_done      (layer_done),
    .err             (err),
    .kernel_sel      (kernel_sel),
    .pu_start        (pu_start),
    .pu_input_req    (pu_input_req),
    .pu_input_ready  (pu_input_ready),
    .pu_input_val    (pu_input_val),
    .pu_output_val   (pu_output_val),
    .pu_output_valid (pu_output_valid),
    .pu_done         (pu_done),
    .ibuf_rd_en      (ibuf_rd_en),
    .ibuf_rd_addr    (ibuf_rd_addr),
    .ibuf_rd_data    (ibuf_rd_data),
    .obuf_wr_en      (obuf_wr_en),
    .obuf_wr_addr    (obuf_wr_addr),
    .obuf_wr_data    (obuf_wr_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Input buffer contents and one-cycle read latency.
  logic [7:0] mem [NPIX];
  initial for (int i = 0; i < NPIX; i++) mem[i] = 8'((i * 3) % 256);
  always @(posedge clock) if (ibuf_rd_en) ibuf_rd_data <= mem[ibuf_rd_addr];

  // Scoreboard capture.
  int          cyc_cnt = 0;
  int          done_cnt = 0;
  int          ld_cyc = 0;
  int          pd_cyc = 0;
  int          rd_q [$];
  int          wr_addr_q [$];
  logic [15:0] wr_data_q [$];

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clock) begin
    if (ibuf_rd_en) rd_q.push_back(int'(ibuf_rd_addr));
    if (obuf_wr_en) begin
      wr_addr_q.push_back(int'(obuf_wr_addr));
      wr_data_q.push_back(obuf_wr_data);
    end
    if (layer_done) begin
      done_cnt++;
      ld_cyc = cyc_cnt;
      check("busy_low_at_done", 32'(layer_busy), 0);
    end
  end

  // Processing-unit model: per-kernel output counts and values set by the test.
  int          nout [NK];
  logic [15:0] vals [NK][5];

  task automatic pu_quiet();
    pu_input_req    = 1'b0;
    pu_output_valid = 1'b0;
    pu_output_val   = '0;
    pu_done         = 1'b0;
  endtask

  task automatic pu_pass(input int k);
    int emitted = 0;
    int cyc;
    @(negedge clock);
    if (!reset) begin pu_quiet(); return; end
    for (int p = 0; p < NPIX; p++) begin
      pu_input_req = 1'b1;
      cyc = 0;
      do begin
        @(posedge clock);
        cyc++;
        @(negedge clock);
      end while (reset && !pu_input_ready && cyc < 20);
      pu_input_req = 1'b0;
      if (!reset) begin pu_quiet(); return; end
      check("ready_spacing", 32'(cyc), 3);
      check("pixel_value", 32'(pu_input_val), 32'((p * 3) % 256));
      if (p % 4 == 3 && p / 4 < nout[k]) begin
        pu_output_valid = 1'b1;
        pu_output_val   = vals[k][p/4];
        emitted++;
      end
      @(negedge clock);
      pu_output_valid = 1'b0;
      if (!reset) begin pu_quiet(); return; end
      repeat ($urandom_range(0, 2)) @(negedge clock);
      if (!reset) begin pu_quiet(); return; end
    end
    @(negedge clock);
    if (!reset) begin pu_quiet(); return; end
    for (int j = emitted; j < nout[k]; j++) begin
      pu_output_valid = 1'b1;
      pu_output_val   = vals[k][j];
      @(negedge clock);
      pu_output_valid = 1'b0;
      if (!reset) begin pu_quiet(); return; end
    end
    pu_done = 1'b1;
    pd_cyc  = cyc_cnt;
    @(negedge clock);
    pu_done = 1'b0;
  endtask

  initial begin
    pu_quiet();
    forever begin
      @(negedge clock);
      while (reset && pu_start) pu_pass(int'(kernel_sel));
    end
  end

  // Reference model of the whole layer.
  function automatic logic [15:0] exp_data(input logic [15:0] v);
`ifdef CONV_SCHED_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic fill_vals();
    for (int k = 0; k < NK; k++)
      for (int j = 0; j < 5; j++) vals[k][j] = 16'($urandom);
  endtask

  task automatic check_layer();
    int          ea [$];
    logic [15:0] ed [$];
    bit          exp_err = 1'b0;
    for (int k = 0; k < NK; k++) begin
      if (nout[k] != OPK) exp_err = 1'b1;
      for (int j = 0; j < nout[k] && j < OPK; j++) begin
        ea.push_back(k * OPK + j);
        ed.push_back(exp_data(vals[k][j]));
      end
    end
    check("write_count", wr_addr_q.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wr_addr_q.size(); i++) begin
      check("write_addr", wr_addr_q[i], ea[i]);
      check("write_data", 32'(wr_data_q[i]), 32'(ed[i]));
    end
    check("read_count", rd_q.size(), NK * NPIX);
    for (int i = 0; i < rd_q.size(); i++) check("read_addr", rd_q[i], i % NPIX);
    check("err_flag", 32'(err), 32'(exp_err));
    check("done_count", done_cnt, 1);
    check("done_latency", ld_cyc - pd_cyc, 1);
    check("busy_after", 32'(layer_busy), 0);
  endtask

  task automatic clear_sb();
    rd_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
  endtask

  task automatic run_layer(input bit hold);
    int n = 0;
    clear_sb();
    @(negedge clock);
    layer_start = 1'b1;
    @(posedge clock);
    #1;
    check("pu_start_after_accept", 32'(pu_start), 1);
    check("busy_after_accept", 32'(layer_busy), 1);
    check("err_cleared", 32'(err), 0);
    if (!hold) layer_start = 1'b0;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clock);
      n++;
    end
    layer_start = 1'b0;
    check("layer_done_seen", 32'(done_cnt > 0), 1);
    repeat (4) @(negedge clock);
  endtask

  initial begin
    int n;
    int n_wr;
    layer_start = 1'b0;
    nout = '{4, 4};
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(layer_busy), 0);
    check("rst_done", 32'(layer_done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ksel", 32'(kernel_sel), 0);
    check("rst_pu_start", 32'(pu_start), 0);
    check("rst_ready", 32'(pu_input_ready), 0);
    check("rst_input_val", 32'(pu_input_val), 0);
    check("rst_rd_en", 32'(ibuf_rd_en), 0);
    check("rst_wr_en", 32'(obuf_wr_en), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Clean layer, including a negative and a small positive result.
    fill_vals();
    vals[0][0] = 16'hFFF0;
    vals[0][1] = 16'h0010;
    run_layer(1'b0);
    check_layer();

    // Too few outputs on kernel 0; kernel 1 must still run.
    nout = '{3, 4};
    fill_vals();
    run_layer(1'b0);
    check_layer();

    // One output too many on kernel 0: the extra write is dropped.
    nout = '{5, 4};
    fill_vals();
    run_layer(1'b0);
    check_layer();

    // layer_start held high for the whole layer.
    nout = '{4, 4};
    fill_vals();
    run_layer(1'b1);
    check_layer();

    // Reset while reading for the second kernel.
    fill_vals();
    clear_sb();
    @(negedge clock);
    layer_start = 1'b1;
    @(negedge clock);
    layer_start = 1'b0;
    n = 0;
    while (!(ibuf_rd_en && kernel_sel == 1'b1) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("second_kernel_read_seen", 32'(ibuf_rd_en && kernel_sel == 1'b1), 1);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(layer_busy), 0);
    check("abort_rd_en", 32'(ibuf_rd_en), 0);
    check("abort_ksel", 32'(kernel_sel), 0);
    check("abort_input_val", 32'(pu_input_val), 0);
    check("abort_rd_addr", 32'(ibuf_rd_addr), 0);
    check("abort_wr_en", 32'(obuf_wr_en), 0);
    n_wr = wr_addr_q.size();
    repeat (5) @(negedge clock);
    check("no_write_in_reset", wr_addr_q.size(), n_wr);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    run_layer(1'b0);
    check_layer();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
